// File: rtl/rx_sampler_pkg.sv
// Shared types and OVERSAMPLE-derived constants for the oversampling character receiver.
package rx_sampler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  function automatic int tick_w(input int oversample);
    return $clog2(oversample);
  endfunction

  function automatic int mid_of(input int oversample);
    return oversample / 2;
  endfunction

endpackage

// File: rtl/rx_bit_voter.sv
// Captures the synced line at ticks MID-1 and MID, and votes 2-of-3 with the live sample at MID+1.
module rx_bit_voter
  import rx_sampler_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int TW         = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  input  logic          sample_en,
  input  logic [TW-1:0] tick,
  output logic          vote,
  output logic          decide
);

  localparam logic [TW-1:0] T_LO  = TW'(mid_of(OVERSAMPLE) - 1);
  localparam logic [TW-1:0] T_MID = TW'(mid_of(OVERSAMPLE));
  localparam logic [TW-1:0] T_HI  = TW'(mid_of(OVERSAMPLE) + 1);

  logic s_lo;
  logic s_mid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_lo  <= 1'b1;
      s_mid <= 1'b1;
    end else if (sample_en) begin
      if (tick == T_LO)  s_lo  <= rx;
      if (tick == T_MID) s_mid <= rx;
    end
  end

  assign decide = sample_en && (tick == T_HI);
  assign vote   = (s_lo & s_mid) | (s_lo & rx) | (s_mid & rx);

endmodule

// File: rtl/rx_char_sampler.sv
// Oversampling serial character receiver with valid/ready output and framing/overrun flags.
// Optional parity bit after the data bits when RX_SAMPLER_PARITY_EN is defined.
module rx_char_sampler
  import rx_sampler_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PARITY_ODD  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 sample_en,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TW = tick_w(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          ODD    = (PARITY_ODD != 0);

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  state_t                 state;
  logic [TW-1:0]          tick;
  logic [TW-1:0]          tick_nxt;
  logic [BW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shift;
  logic                   vote;
  logic                   decide;
  logic                   last;
  logic                   complete;
  logic                   handshake;
  logic                   par_recv;
  logic                   par_fail;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= '1;
    else      sync <= {sync[SYNC_STAGES-2:0], rx_in};
  end

  assign rx_s     = sync[SYNC_STAGES-1];
  assign last     = (tick == T_LAST);
  assign tick_nxt = last ? '0 : tick + TW'(1);

  rx_bit_voter #(
    .OVERSAMPLE(OVERSAMPLE),
    .TW        (TW)
  ) u_voter (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx_s),
    .sample_en(sample_en),
    .tick     (tick),
    .vote     (vote),
    .decide   (decide)
  );

`ifdef RX_SAMPLER_PARITY_EN
  logic par_bit;
  assign par_recv = par_bit;
`else
  // No parity bit on the wire: received parity equals expected, so parity_err stays 0.
  assign par_recv = ^shift ^ ODD;
`endif
  assign par_fail = par_recv != (^shift ^ ODD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tick    <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef RX_SAMPLER_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else if (sample_en) begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            tick  <= TW'(1);
          end
        end
        START: begin
          tick <= tick_nxt;
          if (decide && vote) begin
            state <= IDLE;
            tick  <= '0;
          end else if (last) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          tick <= tick_nxt;
          if (decide) shift <= {vote, shift[DATA_BITS-1:1]};
          if (last) begin
            if (bit_idx == B_LAST) begin
`ifdef RX_SAMPLER_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end
`ifdef RX_SAMPLER_PARITY_EN
        PARITY: begin
          tick <= tick_nxt;
          if (decide) par_bit <= vote;
          if (last)   state   <= STOP;
        end
`endif
        STOP: begin
          tick <= tick_nxt;
          // Back to IDLE at mid-stop so a back-to-back start edge is not missed.
          if (decide) begin
            state <= IDLE;
            tick  <= '0;
          end
        end
        default: begin
          state <= IDLE;
          tick  <= '0;
        end
      endcase
    end
  end

  assign complete  = decide && (state == STOP);
  assign handshake = data_valid && data_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (handshake) begin
        data_valid  <= 1'b0;
        overrun_err <= 1'b0;
      end
      if (complete) begin
        if (!data_valid || data_ready) begin
          data_out   <= shift;
          data_valid <= 1'b1;
          frame_err  <= ~vote;
          parity_err <= par_fail;
        end else begin
          overrun_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_char_sampler.sv
// Scoreboard bench for rx_char_sampler (16x oversampling, 8 data bits, no parity).
module tb_rx_char_sampler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic       sample_en = 1'b0;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun_err;
  logic       busy;

  typedef struct {
    logic [7:0] d;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic ln[160];
  int   tests = 0;
  int   failed = 0;
  int   period = 1;
  int   valid_cycles = 0;
  bit   rand_ready = 1'b0;

  always #5 clk = ~clk;

  rx_char_sampler #(
    .OVERSAMPLE (16),
    .DATA_BITS  (8),
    .SYNC_STAGES(2),
    .PARITY_ODD (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .sample_en  (sample_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun_err(overrun_err),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake is matched against the oldest expected character.
  always @(negedge clk) begin
    if (rst && data_valid) valid_cycles++;
    if (rst && data_valid && data_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_char: got 0x%0h expected none", data_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("data_out", {24'h0, data_out}, {24'h0, mon_e.d});
        check("frame_err", {31'h0, frame_err}, {31'h0, mon_e.fe});
        check("parity_err", {31'h0, parity_err}, 32'h0);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      data_ready = ($urandom_range(0, 1) == 1);
    end
  end

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  task automatic tick(input logic v);
    rx_in = v;
    for (int c = 0; c < period; c++) begin
      sample_en = (c == period - 1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  task automatic build(input logic [7:0] d, input logic stop);
    for (int t = 0; t < 160; t++) begin
      if (t < 16)       ln[t] = 1'b0;
      else if (t < 144) ln[t] = d[(t - 16) / 16];
      else              ln[t] = stop;
    end
  endtask

  // Each bit is the 2-of-3 vote of line ticks 7, 8, 9 of that bit period.
  task automatic push_expected();
    exp_t e;
    for (int i = 0; i < 8; i++)
      e.d[i] = maj3(ln[16 * (i + 1) + 7], ln[16 * (i + 1) + 8], ln[16 * (i + 1) + 9]);
    e.fe = !maj3(ln[151], ln[152], ln[153]);
    exp_q.push_back(e);
  endtask

  task automatic drive_line(input int n);
    for (int t = 0; t < n; t++) tick(ln[t]);
  endtask

  initial begin
    int wait_cnt;
    logic [7:0] d;
    logic stop;
    int pos;

    repeat (3) @(posedge clk);
    #1;
    check("rst_data_valid", {31'h0, data_valid}, 32'h0);
    check("rst_data_out", {24'h0, data_out}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_overrun", {31'h0, overrun_err}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b1;
    idle(4);

    // 0xA5 with consumer always ready: exactly one valid cycle.
    data_ready = 1'b1;
    valid_cycles = 0;
    build(8'hA5, 1'b1); push_expected(); drive_line(160);
    idle(2);
    check("a5_valid_cycles", valid_cycles, 1);
    check("a5_busy_after", {31'h0, busy}, 32'h0);

    // False start: low for ticks 0-3 only.
    valid_cycles = 0;
    repeat (4) tick(1'b0);
    tick(1'b1);
    check("false_start_busy", {31'h0, busy}, 32'h1);
    idle(12);
    check("false_start_idle", {31'h0, busy}, 32'h0);
    check("false_start_no_valid", valid_cycles, 0);

    // Framing error then a clean repeat.
    build(8'h3C, 1'b0); push_expected(); drive_line(160);
    idle(12);
    build(8'h3C, 1'b1); push_expected(); drive_line(160);
    idle(2);

    // Overrun: second character dropped while the first is held.
    data_ready = 1'b0;
    build(8'h11, 1'b1); push_expected(); drive_line(160);
    idle(2);
    build(8'h22, 1'b1); drive_line(160);
    idle(4);
    check("ovr_valid", {31'h0, data_valid}, 32'h1);
    check("ovr_data_held", {24'h0, data_out}, 32'h11);
    check("ovr_flag", {31'h0, overrun_err}, 32'h1);
    data_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_valid_cleared", {31'h0, data_valid}, 32'h0);
    check("ovr_flag_cleared", {31'h0, overrun_err}, 32'h0);

    // Mid-bit glitches on bit 3 of 0xFF.
    build(8'hFF, 1'b1); ln[72] = 1'b0; push_expected(); drive_line(160);
    idle(2);
    build(8'hFF, 1'b1); ln[72] = 1'b0; ln[73] = 1'b0; push_expected(); drive_line(160);
    idle(2);

    // Async reset with a held character and another in flight (bit 4).
    data_ready = 1'b0;
    build(8'h66, 1'b1); push_expected(); drive_line(160);
    idle(2);
    check("pre_rst_valid", {31'h0, data_valid}, 32'h1);
    build(8'h5A, 1'b1); drive_line(16 * 5 + 4);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", {31'h0, data_valid}, 32'h0);
    check("mid_rst_data", {24'h0, data_out}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_overrun", {31'h0, overrun_err}, 32'h0);
    exp_q.delete();
    rx_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    data_ready = 1'b1;
    idle(4);
    build(8'h5A, 1'b1); push_expected(); drive_line(160);
    idle(2);
    period = 3;
    build(8'h5A, 1'b1); push_expected(); drive_line(160);
    idle(2);
    period = 1;

    // Random characters, random consumer readiness, random data-bit glitches.
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      build(d, stop);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        pos = 16 + int'($urandom_range(0, 127));
        ln[pos] = ~ln[pos];
        if ($urandom_range(0, 1) == 1 && pos < 143) ln[pos + 1] = ln[pos];
      end
      push_expected();
      drive_line(160);
      idle(stop ? int'($urandom_range(0, 4)) : 12);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    data_ready = 1'b1;

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 400) begin
      @(posedge clk);
      wait_cnt++;
    end
    @(negedge clk);
    check("drain_queue", exp_q.size(), 0);
    check("final_overrun", {31'h0, overrun_err}, 32'h0);
    check("final_busy", {31'h0, busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/rx_char_sampler.md
Name: rx_char_sampler

Overview:
- Parametrised oversampling serial-character receiver: start-bit detection, mid-bit majority sampling, LSB-first deserialisation, stop-bit check.
- Sits between the raw serial input pin and the character-ID / decode logic.
- Delivers each character through a valid/ready handshake, with framing and overrun flags.
- Generalises the fixed 16x, single-bit sample counter to configurable oversampling and character width. Adds false-start rejection, 3-sample voting, flow control and error reporting.

Parameters:
- OVERSAMPLE, 16, sample ticks per bit period; even, >= 4.
- DATA_BITS, 8, data bits per character; 5..9.
- SYNC_STAGES, 2, input synchroniser depth; >= 2.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; used only with RX_SAMPLER_PARITY_EN.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- rx_in  input  1  serial line; idles high.
- sample_en  input  1  oversample tick; one-cycle pulse, OVERSAMPLE per bit period.
- data_out  output  DATA_BITS  received character; stable while data_valid.
- data_valid  output  1  character held for consumer.
- data_ready  input  1  consumer accepts; transfer when data_valid && data_ready.
- frame_err  output  1  held character had stop bit = 0; qualified by data_valid.
- parity_err  output  1  held character failed parity; qualified by data_valid.
- overrun_err  output  1  sticky: a character was dropped.
- busy  output  1  receiver not in IDLE.

Behaviour:
- Reset (rst low, async): state IDLE, counters 0, synchroniser flops 1, data_out 0, data_valid 0, frame_err 0, parity_err 0, overrun_err 0, busy 0. Reset mid-character discards that character entirely.
- rx_in passes through SYNC_STAGES flops every clk; the flops are not gated by sample_en. All FSM and counter updates occur only on sample_en cycles.
- Tick counter tick: width $clog2(OVERSAMPLE); counts 0..OVERSAMPLE-1 within a bit, then wraps to 0.
- MID = OVERSAMPLE/2. The bit value is the majority of the synchronised samples at ticks MID-1, MID, MID+1, decided at tick MID+1.
- States:
  - IDLE: on a sample_en with synced rx = 0, that tick is tick 0; go to START with tick = 1.
  - START: at the decision tick, vote = 1 means false start: return to IDLE, no output. Vote = 0 means continue; at tick OVERSAMPLE-1 go to DATA with bit_idx = 0.
  - DATA: at the decision tick, shift the vote in LSB-first. At tick OVERSAMPLE-1, bit_idx++. After bit DATA_BITS-1, go to STOP (or PARITY when enabled).
  - STOP: at the decision tick, latch the character and frame_err = ~vote, then go straight to IDLE. The remaining half stop bit is not waited out, so a back-to-back start bit is caught.
- Output latency: data_valid rises on the clk after the stop decision tick and holds until the handshake.
- A new character completing while data_valid = 1 and no handshake that cycle: the new character is dropped, held data is unchanged, overrun_err is set.
- Handshake in the same cycle as a completion: the new character loads, data_valid stays 1, no overrun.
- overrun_err clears on the next handshake.
- busy = (state != IDLE).

Optional Feature:
- Macro: RX_SAMPLER_PARITY_EN.
- Defined: a PARITY state follows DATA and is voted like a data bit. parity_err = received parity != expected, where expected = XOR(data) ^ PARITY_ODD. parity_err is latched with the character.
- Undefined: no PARITY state; parity_err is tied 0; the frame is start + DATA_BITS + stop.

Decomposition:
- Package rx_sampler_pkg holds:
  - state enum typedef (IDLE, START, DATA, PARITY, STOP);
  - tick-width and MID constants derived from OVERSAMPLE.
- One sub-module, rx_bit_voter: takes the synced rx, sample_en and tick; captures the three mid samples; outputs the vote and a decision strobe.

Test Plan (OVERSAMPLE=16, DATA_BITS=8, sample_en every cycle unless stated):
- 0xA5 8N1, data_ready=1 -> one-cycle data_valid with data_out=0xA5, frame_err=0, busy low after stop tick 9.
- Idle line driven low for ticks 0-3 only -> busy high until tick 9, then 0; data_valid never asserts.
- 0x3C with stop bit driven 0 -> data_valid, data_out=0x3C, frame_err=1. A following 0x3C with a valid stop gives frame_err=0.
- data_ready=0, send 0x11 then 0x22 -> data_out stays 0x11, overrun_err=1. Raise data_ready -> handshake, data_valid=0, overrun_err=0.
- 0xFF with rx low for the single tick 8 of bit 3 -> data_out=0xFF. The same with ticks 8-9 low -> data_out=0xF7.
- rst pulsed low during bit 4 -> all outputs at reset values immediately. The next 0x5A is received correctly. sample_en every 3rd cycle with 0x5A also yields 0x5A.
